// File: rtl/lenet_fc_pkg.sv
// lenet_fc_pkg: shared constants and types for the LeNet-5 FC layer sequencer.
//   - layer ids (FC1/FC2/FC3) and the last valid id
//   - per-layer geometry (fan-in, fan-out) and packed ROM bases
//   - buffer select codes for the activation read and result write sides
//   - layer configuration struct and sequencer state enum
package lenet_fc_pkg;

  localparam logic [1:0] LAYER_FC1  = 2'd0;
  localparam logic [1:0] LAYER_FC2  = 2'd1;
  localparam logic [1:0] LAYER_FC3  = 2'd2;
  localparam logic [1:0] LAYER_LAST = 2'd2;

  localparam logic [8:0] FC1_N_IN  = 9'd400;
  localparam logic [8:0] FC2_N_IN  = 9'd120;
  localparam logic [8:0] FC3_N_IN  = 9'd84;
  localparam logic [6:0] FC1_N_OUT = 7'd120;
  localparam logic [6:0] FC2_N_OUT = 7'd84;
  localparam logic [6:0] FC3_N_OUT = 7'd10;

  // Weight ROM packs FC1|FC2|FC3 row-major, bias ROM packs 120|84|10.
  localparam logic [15:0] FC1_W_BASE = 16'd0;
  localparam logic [15:0] FC2_W_BASE = 16'd48000;
  localparam logic [15:0] FC3_W_BASE = 16'd58080;
  localparam logic [7:0]  FC1_B_BASE = 8'd0;
  localparam logic [7:0]  FC2_B_BASE = 8'd120;
  localparam logic [7:0]  FC3_B_BASE = 8'd204;

  localparam logic [1:0] SEL_A      = 2'd0;  // pool output
  localparam logic [1:0] SEL_B      = 2'd1;  // FC1 output
  localparam logic [1:0] SEL_C      = 2'd2;  // FC2 output
  localparam logic [1:0] SEL_SCORES = 2'd3;  // class scores

  typedef struct packed {
    logic [8:0]  n_in;
    logic [6:0]  n_out;
    logic [15:0] w_base;
    logic [7:0]  b_base;
    logic [1:0]  a_sel;
    logic [1:0]  o_sel;
    logic        relu;
  } layer_cfg_t;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_BIAS_RD    = 3'd1,
    S_BIAS_LD    = 3'd2,
    S_MAC        = 3'd3,
    S_DRAIN      = 3'd4,
    S_WRITE      = 3'd5,
    S_NEXT_LAYER = 3'd6
  } state_e;

endpackage

// File: rtl/fc_layer_cfg.sv
// fc_layer_cfg: combinational layer table lookup.
//   layer  in   2   layer id (0=FC1, 1=FC2, 2=FC3; 3 returns all zeros)
//   cfg    out      {n_in, n_out, w_base, b_base, a_sel, o_sel, relu}
module fc_layer_cfg
  import lenet_fc_pkg::*;
(
  input  logic [1:0] layer,
  output layer_cfg_t cfg
);

  always_comb begin
    cfg = '0;
    case (layer)
      LAYER_FC1: begin
        cfg.n_in   = FC1_N_IN;
        cfg.n_out  = FC1_N_OUT;
        cfg.w_base = FC1_W_BASE;
        cfg.b_base = FC1_B_BASE;
        cfg.a_sel  = SEL_A;
        cfg.o_sel  = SEL_B;
        cfg.relu   = 1'b1;
      end
      LAYER_FC2: begin
        cfg.n_in   = FC2_N_IN;
        cfg.n_out  = FC2_N_OUT;
        cfg.w_base = FC2_W_BASE;
        cfg.b_base = FC2_B_BASE;
        cfg.a_sel  = SEL_B;
        cfg.o_sel  = SEL_C;
        cfg.relu   = 1'b1;
      end
      LAYER_FC3: begin
        cfg.n_in   = FC3_N_IN;
        cfg.n_out  = FC3_N_OUT;
        cfg.w_base = FC3_W_BASE;
        cfg.b_base = FC3_B_BASE;
        cfg.a_sel  = SEL_C;
        cfg.o_sel  = SEL_SCORES;
        cfg.relu   = 1'b0;
      end
      default: cfg = '0;
    endcase
  end

endmodule

// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer: drives one shared MAC datapath through FC1..FC3 of LeNet-5.
//   clk, rst            clock, async active-high reset
//   start               1-cycle pulse, honoured only while idle
//   cfg_first/cfg_last  layer range, sampled on an accepted start
//   busy, done, err     run status (err sticky until next accepted start)
//   layer               layer currently executing
//   b_addr/w_addr/a_addr/a_sel   bias, weight, activation read side (1-cycle latency)
//   acc_load/mac_en     accumulator load-bias / multiply-accumulate strobes
//   o_we/o_addr/o_sel/o_relu     result write side
// Every output is a flop; the next-cycle value is computed alongside the next state.
module fc_layer_sequencer
  import lenet_fc_pkg::*;
#(
  parameter int W_AW = 16,
  parameter int B_AW = 8,
  parameter int A_AW = 9,
  parameter int O_AW = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      cfg_first,
  input  logic [1:0]      cfg_last,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [1:0]      layer,
  output logic [B_AW-1:0] b_addr,
  output logic [W_AW-1:0] w_addr,
  output logic [A_AW-1:0] a_addr,
  output logic [1:0]      a_sel,
  output logic            acc_load,
  output logic            mac_en,
  output logic            o_we,
  output logic [O_AW-1:0] o_addr,
  output logic [1:0]      o_sel,
  output logic            o_relu
);

  state_e          state_q, state_d;
  logic [1:0]      layer_q, layer_d, last_q, last_d;
  logic [6:0]      n_q, n_d;
  logic [8:0]      k_q, k_d;
  logic [15:0]     w_run_q, w_run_d;  // w_base + n*N_in, advanced per neuron
  logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [B_AW-1:0] b_addr_q, b_addr_d;
  logic [W_AW-1:0] w_addr_q, w_addr_d;
  logic [A_AW-1:0] a_addr_q, a_addr_d;
  logic [1:0]      a_sel_q, a_sel_d, o_sel_q, o_sel_d;
  logic            acc_load_q, acc_load_d, mac_en_q, mac_en_d, o_we_q, o_we_d;
  logic            o_relu_q, o_relu_d;
  logic [O_AW-1:0] o_addr_q, o_addr_d;

  logic [1:0]      cfg_layer;
  layer_cfg_t      cur_cfg;
  logic            cfg_ok;

  // While idle the table looks at the requested first layer so the first bias
  // address can be issued straight out of the start cycle.
  assign cfg_layer = (state_q == S_IDLE) ? cfg_first : layer_q;
  assign cfg_ok    = (cfg_first <= cfg_last) && (cfg_last <= LAYER_LAST);

  fc_layer_cfg u_cfg (
    .layer (cfg_layer),
    .cfg   (cur_cfg)
  );

  always_comb begin
    state_d    = state_q;
    layer_d    = layer_q;
    last_d     = last_q;
    n_d        = n_q;
    k_d        = k_q;
    w_run_d    = w_run_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    b_addr_d   = '0;
    w_addr_d   = '0;
    a_addr_d   = '0;
    a_sel_d    = 2'd0;
    acc_load_d = 1'b0;
    mac_en_d   = 1'b0;
    o_we_d     = 1'b0;
    o_addr_d   = '0;
    o_sel_d    = 2'd0;
    o_relu_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (cfg_ok) begin
            state_d  = S_BIAS_RD;
            layer_d  = cfg_first;
            last_d   = cfg_last;
            n_d      = 7'd0;
            k_d      = 9'd0;
            w_run_d  = cur_cfg.w_base;
            busy_d   = 1'b1;
            b_addr_d = B_AW'(cur_cfg.b_base);
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BIAS_RD: begin
        state_d    = S_BIAS_LD;
        busy_d     = 1'b1;
        acc_load_d = 1'b1;
        k_d        = 9'd0;
        w_addr_d   = W_AW'(w_run_q);
        a_sel_d    = cur_cfg.a_sel;
      end
      S_BIAS_LD: begin
        state_d  = S_MAC;
        busy_d   = 1'b1;
        mac_en_d = 1'b1;
        k_d      = 9'd1;
        a_addr_d = A_AW'(9'd1);
        w_addr_d = W_AW'(w_run_q + 16'd1);
        a_sel_d  = cur_cfg.a_sel;
      end
      S_MAC: begin
        busy_d   = 1'b1;
        mac_en_d = 1'b1;
        if (k_q < (cur_cfg.n_in - 9'd1)) begin
          k_d      = k_q + 9'd1;
          a_addr_d = A_AW'(k_q + 9'd1);
          w_addr_d = W_AW'(w_run_q + 16'(k_q) + 16'd1);
          a_sel_d  = cur_cfg.a_sel;
        end else begin
          // Last operand pair is still in flight; drain it without new reads.
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d  = S_WRITE;
        busy_d   = 1'b1;
        o_we_d   = 1'b1;
        o_addr_d = O_AW'(n_q);
        o_sel_d  = cur_cfg.o_sel;
        o_relu_d = cur_cfg.relu;
      end
      S_WRITE: begin
        if (n_q < (cur_cfg.n_out - 7'd1)) begin
          state_d  = S_BIAS_RD;
          busy_d   = 1'b1;
          n_d      = n_q + 7'd1;
          w_run_d  = w_run_q + 16'(cur_cfg.n_in);
          b_addr_d = B_AW'(cur_cfg.b_base + 8'(n_q) + 8'd1);
        end else if (layer_q < last_q) begin
          state_d = S_NEXT_LAYER;
          busy_d  = 1'b1;
          layer_d = layer_q + 2'd1;
          n_d     = 7'd0;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          layer_d = 2'd0;
        end
      end
      S_NEXT_LAYER: begin
        // layer_q already names the new layer here, so cur_cfg is its table row.
        state_d  = S_BIAS_RD;
        busy_d   = 1'b1;
        n_d      = 7'd0;
        w_run_d  = cur_cfg.w_base;
        b_addr_d = B_AW'(cur_cfg.b_base);
      end
      default: begin
        state_d = S_IDLE;
        layer_d = 2'd0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      layer_q    <= 2'd0;
      last_q     <= 2'd0;
      n_q        <= 7'd0;
      k_q        <= 9'd0;
      w_run_q    <= 16'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      b_addr_q   <= '0;
      w_addr_q   <= '0;
      a_addr_q   <= '0;
      a_sel_q    <= 2'd0;
      acc_load_q <= 1'b0;
      mac_en_q   <= 1'b0;
      o_we_q     <= 1'b0;
      o_addr_q   <= '0;
      o_sel_q    <= 2'd0;
      o_relu_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      last_q     <= last_d;
      n_q        <= n_d;
      k_q        <= k_d;
      w_run_q    <= w_run_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      b_addr_q   <= b_addr_d;
      w_addr_q   <= w_addr_d;
      a_addr_q   <= a_addr_d;
      a_sel_q    <= a_sel_d;
      acc_load_q <= acc_load_d;
      mac_en_q   <= mac_en_d;
      o_we_q     <= o_we_d;
      o_addr_q   <= o_addr_d;
      o_sel_q    <= o_sel_d;
      o_relu_q   <= o_relu_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign layer    = layer_q;
  assign b_addr   = b_addr_q;
  assign w_addr   = w_addr_q;
  assign a_addr   = a_addr_q;
  assign a_sel    = a_sel_q;
  assign acc_load = acc_load_q;
  assign mac_en   = mac_en_q;
  assign o_we     = o_we_q;
  assign o_addr   = o_addr_q;
  assign o_sel    = o_sel_q;
  assign o_relu   = o_relu_q;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb_fc_layer_sequencer: self-checking bench for fc_layer_sequencer.
// A trace model expands each run into its per-cycle output records from the
// layer table; one negedge process compares the DUT against it every cycle.
// A behavioural MAC datapath driven by the DUT strobes produces class scores.
module tb_fc_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  cfg_first, cfg_last;
  logic        busy, done, err;
  logic [1:0]  layer;
  logic [7:0]  b_addr;
  logic [15:0] w_addr;
  logic [8:0]  a_addr;
  logic [1:0]  a_sel;
  logic        acc_load, mac_en, o_we;
  logic [6:0]  o_addr;
  logic [1:0]  o_sel;
  logic        o_relu;

  always #5 clk = ~clk;

  fc_layer_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .cfg_first(cfg_first), .cfg_last(cfg_last),
    .busy(busy), .done(done), .err(err), .layer(layer), .b_addr(b_addr), .w_addr(w_addr),
    .a_addr(a_addr), .a_sel(a_sel), .acc_load(acc_load), .mac_en(mac_en), .o_we(o_we),
    .o_addr(o_addr), .o_sel(o_sel), .o_relu(o_relu)
  );

  typedef struct packed {
    logic busy, done, err;
    logic [1:0]  layer;
    logic [7:0]  b_addr;
    logic [15:0] w_addr;
    logic [8:0]  a_addr;
    logic [1:0]  a_sel;
    logic acc_load, mac_en, o_we;
    logic [6:0]  o_addr;
    logic [1:0]  o_sel;
    logic o_relu;
  } obs_t;

  int n_in_t   [3] = '{400, 120, 84};
  int n_out_t  [3] = '{120, 84, 10};
  int w_base_t [3] = '{0, 48000, 58080};
  int b_base_t [3] = '{0, 120, 204};
  int a_sel_t  [3] = '{0, 1, 2};
  int o_sel_t  [3] = '{1, 2, 3};
  int relu_t   [3] = '{1, 1, 0};

  int   errors = 0;
  int   checks = 0;
  obs_t exp_q[$];
  logic idle_err = 1'b0;
  int   cyc_cnt = 0;
  int   t0 = 0;

  task automatic check(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic string fmt(input obs_t r);
    return $sformatf("busy=%0d done=%0d err=%0d layer=%0d b=%0d w=%0d a=%0d asel=%0d ld=%0d mac=%0d we=%0d oa=%0d osel=%0d relu=%0d",
                     r.busy, r.done, r.err, r.layer, r.b_addr, r.w_addr, r.a_addr, r.a_sel,
                     r.acc_load, r.mac_en, r.o_we, r.o_addr, r.o_sel, r.o_relu);
  endfunction

  function automatic obs_t sample_obs();
    obs_t r;
    r.busy = busy; r.done = done; r.err = err; r.layer = layer; r.b_addr = b_addr;
    r.w_addr = w_addr; r.a_addr = a_addr; r.a_sel = a_sel; r.acc_load = acc_load;
    r.mac_en = mac_en; r.o_we = o_we; r.o_addr = o_addr; r.o_sel = o_sel; r.o_relu = o_relu;
    return r;
  endfunction

  // Expand a valid layer range into the per-cycle records it must produce.
  task automatic gen_run(input int first, input int last);
    obs_t r;
    for (int l = first; l <= last; l++) begin
      for (int n = 0; n < n_out_t[l]; n++) begin
        int wb;
        wb = w_base_t[l] + n * n_in_t[l];
        r = '0; r.busy = 1'b1; r.layer = 2'(l); r.b_addr = 8'(b_base_t[l] + n);
        exp_q.push_back(r);
        r = '0; r.busy = 1'b1; r.layer = 2'(l); r.acc_load = 1'b1;
        r.w_addr = 16'(wb); r.a_sel = 2'(a_sel_t[l]);
        exp_q.push_back(r);
        for (int k = 1; k < n_in_t[l]; k++) begin
          r = '0; r.busy = 1'b1; r.layer = 2'(l); r.mac_en = 1'b1;
          r.a_addr = 9'(k); r.w_addr = 16'(wb + k); r.a_sel = 2'(a_sel_t[l]);
          exp_q.push_back(r);
        end
        r = '0; r.busy = 1'b1; r.layer = 2'(l); r.mac_en = 1'b1;
        exp_q.push_back(r);
        r = '0; r.busy = 1'b1; r.layer = 2'(l); r.o_we = 1'b1; r.o_addr = 7'(n);
        r.o_sel = 2'(o_sel_t[l]); r.o_relu = 1'(relu_t[l]);
        exp_q.push_back(r);
      end
      if (l < last) begin
        r = '0; r.busy = 1'b1; r.layer = 2'(l + 1);
        exp_q.push_back(r);
      end
    end
    r = '0; r.done = 1'b1;
    exp_q.push_back(r);
  endtask

  // Cycle counter used for latency measurement.
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Per-cycle comparison against the trace model (idle outputs when the trace is empty).
  always @(negedge clk) begin
    obs_t a, e;
    a = sample_obs();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      idle_err = e.err;
    end else begin
      e = '0;
      e.err = idle_err;
    end
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL trace t=%0t got {%s} required {%s}", $time, fmt(a), fmt(e));
    end
  end

  // Strobe monitor: exclusivity, mac pulses per neuron, write/done/strobe tallies.
  int mac_cnt = 0, done_cnt = 0, strobe_cnt = 0, w_max = 0;
  int we_cnt [4] = '{0, 0, 0, 0};
  always @(negedge clk) begin
    if (acc_load | mac_en | o_we)
      check("strobe_exclusive", int'(acc_load) + int'(mac_en) + int'(o_we), 1);
    if (acc_load) mac_cnt = 0;
    else if (mac_en) mac_cnt++;
    if (o_we) begin
      check("mac_per_neuron", mac_cnt, (layer < 2'd3) ? n_in_t[layer] : -1);
      we_cnt[o_sel]++;
    end
    if (done) done_cnt++;
    if (acc_load | mac_en | o_we) strobe_cnt++;
    if (busy && int'(w_addr) > w_max) w_max = int'(w_addr);
  end

  // Behavioural datapath: sync-read ROMs/buffers, accumulator, class-score sink.
  int  wrom [0:58919];
  int  brom [0:213];
  int  abuf [0:2][0:399];
  int  b_data, w_data, a_data, acc;
  int  scores [10];
  int  golden [10];
  bit  clr_scores = 1'b0;
  always @(posedge clk) begin
    b_data <= (b_addr < 8'd214) ? brom[b_addr] : 0;
    w_data <= (w_addr < 16'd58920) ? wrom[w_addr] : 0;
    a_data <= (a_sel < 2'd3 && a_addr < 9'd400) ? abuf[a_sel][a_addr] : 0;
    if (acc_load) acc <= b_data;
    else if (mac_en) acc <= acc + a_data * w_data;
    if (clr_scores) begin
      for (int i = 0; i < 10; i++) scores[i] <= -1;
    end else if (o_we && o_sel == 2'd3 && o_addr < 7'd10) begin
      scores[o_addr] <= acc;
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; exp_q.delete(); idle_err = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] f, input logic [1:0] l);
    obs_t r;
    @(posedge clk); #1;
    cfg_first = f; cfg_last = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; t0 = cyc_cnt;
    if (f <= l && l <= 2'd2) gen_run(int'(f), int'(l));
    else begin
      r = '0; r.done = 1'b1; r.err = 1'b1;
      exp_q.push_back(r);
    end
  endtask

  task automatic wait_done(input int max_cyc, output int cyc);
    cyc = -1;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = cyc_cnt - t0;
        break;
      end
      if (cyc_cnt - t0 > max_cyc) begin
        checks++; errors++;
        $display("FAIL done_timeout: no done after %0d cycles, required done", max_cyc);
        apply_reset();
        break;
      end
    end
  endtask

  task automatic clear_scores();
    @(posedge clk); #1; clr_scores = 1'b1;
    @(posedge clk); #1; clr_scores = 1'b0;
  endtask

  task automatic check_scores(input string tag);
    for (int n = 0; n < 10; n++) check($sformatf("%s_score%0d", tag, n), scores[n], golden[n]);
  endtask

  int cyc, d0, s0, w0, w1, w2;
  bit found;

  initial begin
    rst = 1'b0; start = 1'b0; cfg_first = 2'd0; cfg_last = 2'd0;
    for (int k = 0; k < 84; k++) abuf[2][k] = k;
    for (int n = 0; n < 10; n++) begin
      brom[204 + n] = 10 * n;
      for (int k = 0; k < 84; k++) wrom[58080 + n * 84 + k] = n + 1;
    end
    for (int n = 0; n < 10; n++) begin
      golden[n] = brom[204 + n];
      for (int k = 0; k < 84; k++) golden[n] += abuf[2][k] * wrom[58080 + n * 84 + k];
    end
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_w_addr", w_addr, 0);
    check("reset_layer", layer, 0);
    @(posedge clk); #1 rst = 1'b0;

    // FC3-only run: bit-exact scores and 10*87 cycle latency.
    clear_scores();
    do_start(2'd2, 2'd2);
    wait_done(2000, cyc);
    check("fc3_latency", cyc, 870);
    @(negedge clk);
    check_scores("fc3");
    check("fc3_score0_literal", scores[0], 3486);
    check("fc3_score9_literal", scores[9], 34950);
    check("fc3_err", err, 0);

    // Full FC1..FC3 run.
    d0 = done_cnt; w0 = we_cnt[1]; w1 = we_cnt[2]; w2 = we_cnt[3];
    do_start(2'd0, 2'd2);
    wait_done(70000, cyc);
    check("full_latency", cyc, 120 * 403 + 1 + 84 * 123 + 1 + 10 * 87);
    @(negedge clk);
    check("full_we_fc1", we_cnt[1] - w0, 120);
    check("full_we_fc2", we_cnt[2] - w1, 84);
    check("full_we_fc3", we_cnt[3] - w2, 10);
    check("full_done_count", done_cnt - d0, 1);
    check("full_w_addr_max", w_max, 58919);

    // Invalid ranges: done+err next cycle, no datapath strobes.
    s0 = strobe_cnt;
    do_start(2'd2, 2'd1);
    @(negedge clk);
    check("inv21_done", done, 1);
    check("inv21_err", err, 1);
    check("inv21_busy", busy, 0);
    @(negedge clk);
    check("inv21_done_pulse", done, 0);
    check("inv21_err_sticky", err, 1);
    do_start(2'd3, 2'd3);
    @(negedge clk);
    check("inv33_done", done, 1);
    check("inv33_err", err, 1);
    repeat (3) @(negedge clk);
    check("inv_strobes", strobe_cnt - s0, 0);

    // FC2-only run with starts pulsed mid-run.
    d0 = done_cnt;
    do_start(2'd1, 2'd1);
    repeat (5) @(posedge clk);
    #1 cfg_first = 2'd2; cfg_last = 2'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (294) @(posedge clk);
    #1 cfg_first = 2'd0; cfg_last = 2'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(12000, cyc);
    check("fc2_latency", cyc, 84 * 123);
    @(negedge clk);
    check("fc2_done_count", done_cnt - d0, 1);
    check("fc2_err_cleared", err, 0);

    // Reset in the middle of FC1 neuron 37, then a fresh FC3 run.
    do_start(2'd0, 2'd2);
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      @(negedge clk);
      if (busy && layer == 2'd0 && b_addr == 8'd37) found = 1'b1;
    end
    check("rst_reached_n37", int'(found), 1);
    repeat (50) @(posedge clk);
    #1 rst = 1'b1; exp_q.delete(); idle_err = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_mac_en", mac_en, 0);
    check("rst_w_addr", w_addr, 0);
    check("rst_a_addr", a_addr, 0);
    check("rst_layer", layer, 0);
    @(posedge clk); #1 rst = 1'b0;
    clear_scores();
    d0 = done_cnt;
    do_start(2'd2, 2'd2);
    wait_done(2000, cyc);
    check("post_rst_latency", cyc, 870);
    @(negedge clk);
    check("post_rst_done_count", done_cnt - d0, 1);
    check_scores("post_rst");

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
